// File: rtl/lcd_scroll_badge.sv
// lcd_scroll_badge: HD44780 4-bit driver that inits the panel and repaints a (scrolling) window of a message ROM
// Ports: CLK, RST (sync, active-high); en keeps repainting; char_addr/char_data look up the message
// (combinational ROM); busy is low only in IDLE; RS, E, D4..D7 drive the LCD pins directly.
module lcd_scroll_badge #(
    parameter int CLK_DIV    = 4,
    parameter int POR_CYCLES = 1000,
    parameter int CMD_WAIT   = 50,
    parameter int CLR_WAIT   = 2000,
    parameter int MSG_LEN    = 32,
    parameter int COLS       = 16,
    parameter int LINES      = 1,
    parameter int SCROLL     = 1,
    parameter int SCROLL_DIV = 8,
    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          en,
    output logic [AW-1:0] char_addr,
    input  logic [7:0]    char_data,
    output logic          busy,
    output logic          RS,
    output logic          E,
    output logic          D4,
    output logic          D5,
    output logic          D6,
    output logic          D7
);
    typedef enum logic [3:0] {
        POR_WAIT, INIT8, INIT4, FUNC, DISP, CLR, ENTRY, IDLE,
        ADDR, CHARS, ADDR2, CHARS2, FRAME_END
    } state_t;
    typedef enum logic [1:0] {SETUP, HIGH, HOLD, WAIT} phase_t;

    localparam logic [AW-1:0] LAST     = AW'(MSG_LEN - 1);
    localparam logic [5:0]    COL_LAST = 6'(COLS - 1);

    state_t        st, st_n;
    phase_t        ph;
    logic          nib;
    logic [31:0]   tmr, lim, wl, fcnt;
    logic [5:0]    col;
    logic [AW-1:0] offset;
    logic [7:0]    dat, byte_v;
    logic          xfer, data, first, ph_end, byte_end;

    always_comb begin
        xfer = !(st inside {POR_WAIT, IDLE, FRAME_END});
        data = st inside {CHARS, CHARS2};
        // first setup cycle of a data byte: the ROM output is used live and latched at this edge
        first = data && ph == SETUP && !nib && tmr == 32'd0;
        wl = st == CLR ? 32'(CLR_WAIT) : 32'(CMD_WAIT);
        lim = st == POR_WAIT ? 32'(POR_CYCLES) : ph == WAIT ? wl : 32'(CLK_DIV);
        ph_end = tmr + 32'd1 >= lim;
        // a zero-length wait finishes the byte straight out of the low-nibble hold
        byte_end = xfer && ph_end && (ph == WAIT || (ph == HOLD && nib && wl == 32'd0));
        case (st)
            INIT8:         byte_v = 8'h33;
            INIT4:         byte_v = 8'h22;
            FUNC:          byte_v = LINES == 2 ? 8'h28 : 8'h20;
            DISP:          byte_v = 8'h0C;
            CLR:           byte_v = 8'h01;
            ENTRY:         byte_v = 8'h06;
            ADDR:          byte_v = 8'h80;
            ADDR2:         byte_v = 8'hC0;
            CHARS, CHARS2: byte_v = first ? char_data : dat;
            default:       byte_v = 8'h00;
        endcase
        st_n = st;
        case (st)
            POR_WAIT:  if (ph_end) st_n = INIT8;
            INIT8:     if (byte_end && col == 6'd2) st_n = INIT4;
            INIT4:     if (byte_end) st_n = FUNC;
            FUNC:      if (byte_end) st_n = DISP;
            DISP:      if (byte_end) st_n = CLR;
            CLR:       if (byte_end) st_n = ENTRY;
            ENTRY:     if (byte_end) st_n = IDLE;
            IDLE:      if (en) st_n = ADDR;
            ADDR:      if (byte_end) st_n = CHARS;
            CHARS:     if (byte_end && col == COL_LAST) st_n = LINES == 2 ? ADDR2 : FRAME_END;
            ADDR2:     if (byte_end) st_n = CHARS2;
            CHARS2:    if (byte_end && col == COL_LAST) st_n = FRAME_END;
            default:   st_n = IDLE;
        endcase
        busy = st != IDLE;
        E = xfer && ph == HIGH;
        RS = data;
        {D7, D6, D5, D4} = xfer ? (nib ? byte_v[3:0] : byte_v[7:4]) : 4'h0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            st        <= POR_WAIT;
            ph        <= SETUP;
            nib       <= 1'b0;
            tmr       <= '0;
            col       <= '0;
            offset    <= '0;
            fcnt      <= '0;
            dat       <= '0;
            char_addr <= '0;
        end else begin
            st <= st_n;
            if (first) dat <= char_data;
            // init nibbles are single low-nibble transfers of 0x33 / 0x22
            if (st_n != st) begin
                ph  <= SETUP;
                tmr <= '0;
                col <= '0;
                nib <= st_n inside {INIT8, INIT4};
            end else if (byte_end) begin
                ph  <= SETUP;
                tmr <= '0;
                col <= col + 6'd1;
                nib <= st == INIT8;
            end else if (xfer && ph_end) begin
                tmr <= '0;
                ph  <= ph == HOLD && !nib ? SETUP : phase_t'(ph + 2'd1);
                nib <= nib || ph == HOLD;
            end else tmr <= tmr + 32'd1;
            // line 2 continues from where line 1 stopped, so one running pointer covers both
            if (st == IDLE && en) char_addr <= offset;
            else if (byte_end && data) char_addr <= char_addr == LAST ? '0 : char_addr + AW'(1);
            if (st == FRAME_END) begin
                if (SCROLL != 0 && fcnt + 32'd1 >= 32'(SCROLL_DIV)) begin
                    fcnt   <= '0;
                    offset <= offset == LAST ? '0 : offset + AW'(1);
                end else fcnt <= fcnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_lcd_scroll_badge.sv
// tb_lcd_scroll_badge: directed checks of init sequence, frame content, scroll, reset and en handling
module tb_lcd_scroll_badge;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_a, en_a, busy_a, rs_a, e_a, d4_a, d5_a, d6_a, d7_a;
    logic [2:0] addr_a;
    logic [7:0] data_a;
    logic       rst_b, en_b, busy_b, rs_b, e_b, d4_b, d5_b, d6_b, d7_b;
    logic [2:0] addr_b;
    logic [7:0] data_b;

    function automatic logic [7:0] rom_a(input logic [2:0] a);
        case (a)
            3'd0:       return 8'h48;
            3'd1:       return 8'h45;
            3'd2, 3'd3: return 8'h4C;
            3'd4:       return 8'h4F;
            default:    return 8'h3F;
        endcase
    endfunction
    assign data_a = rom_a(addr_a);
    assign data_b = 8'h41 + {5'd0, addr_b};

    lcd_scroll_badge #(.CLK_DIV(2), .POR_CYCLES(10), .CMD_WAIT(4), .CLR_WAIT(20), .MSG_LEN(5),
                       .COLS(8), .LINES(1), .SCROLL(1), .SCROLL_DIV(2)) dut_a (
        .CLK(clk), .RST(rst_a), .en(en_a), .char_addr(addr_a), .char_data(data_a), .busy(busy_a),
        .RS(rs_a), .E(e_a), .D4(d4_a), .D5(d5_a), .D6(d6_a), .D7(d7_a));

    lcd_scroll_badge #(.CLK_DIV(1), .POR_CYCLES(3), .CMD_WAIT(2), .CLR_WAIT(3), .MSG_LEN(8),
                       .COLS(4), .LINES(2), .SCROLL(0), .SCROLL_DIV(1)) dut_b (
        .CLK(clk), .RST(rst_b), .en(en_b), .char_addr(addr_b), .char_data(data_b), .busy(busy_b),
        .RS(rs_b), .E(e_b), .D4(d4_b), .D5(d5_b), .D6(d6_b), .D7(d7_b));

    // every E rise logs {RS, D7..D4}, the cycle, and the address on the ROM port
    logic [4:0] nq_a[$], nq_b[$];
    int         tq_a[$];
    logic [2:0] aq_b[$];
    logic       pe_a = 1'b0, pe_b = 1'b0;
    always @(negedge clk) begin
        if (e_a && !pe_a) begin
            nq_a.push_back({rs_a, d7_a, d6_a, d5_a, d4_a});
            tq_a.push_back(cyc);
        end
        if (e_b && !pe_b) begin
            nq_b.push_back({rs_b, d7_b, d6_b, d5_b, d4_b});
            aq_b.push_back(addr_b);
        end
        pe_a = e_a;
        pe_b = e_b;
    end

    int total = 0, bad = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] bytes_of(input logic [4:0] q[$], input int b, input int n);
        logic [63:0] v = '0;
        for (int j = 0; j < n; j++) v = {v[55:0], q[b+2*j][3:0], q[b+2*j+1][3:0]};
        return v;
    endfunction

    function automatic logic [15:0] rs_of(input logic [4:0] q[$], input int b, input int n);
        logic [15:0] v = '0;
        for (int j = 0; j < 2 * n; j++) v = {v[14:0], q[b+j][4]};
        return v;
    endfunction

    localparam logic [4:0] INIT_NIB [12] = '{5'h3, 5'h3, 5'h3, 5'h2, 5'h2, 5'h0,
                                             5'h0, 5'hC, 5'h0, 5'h1, 5'h0, 5'h6};

    // r is the cycle count right after the edge that sampled RST high (that edge is cycle 1)
    task automatic check_init_a(input string tag, input int r);
        for (int n = 0; n < 600 && busy_a !== 1'b0; n++) @(negedge clk);
        check({tag, "_busy_low"}, busy_a, 0);
        check({tag, "_nibbles"}, nq_a.size(), 12);
        check({tag, "_first_e"}, tq_a[0] - r + 1, 13);
        for (int i = 0; i < 12; i++) check($sformatf("%s_nib%0d", tag, i), nq_a[i], INIT_NIB[i]);
        check({tag, "_nib_gap"}, tq_a[1] - tq_a[0], 10);
        check({tag, "_byte_gap"}, tq_a[6] - tq_a[4], 16);
        check({tag, "_clr_gap"}, tq_a[10] - tq_a[8], 32);
        check({tag, "_idle_pins"}, {e_a, rs_a, d7_a, d6_a, d5_a, d4_a}, 0);
    endtask

    initial begin
        int r;
        int fb;
        logic [31:0] ap;
        rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        @(posedge clk);
        #1 r = cyc;
        @(negedge clk);
        check("a_reset_pins", {e_a, rs_a, d7_a, d6_a, d5_a, d4_a, busy_a, addr_a}, 10'h008);
        check("b_reset_busy", busy_b, 1);
        rst_a = 1'b0; rst_b = 1'b0;
        check_init_a("a_init", r);

        // frames with scrolling: 18 nibbles per frame (0x80 + 8 chars)
        nq_a.delete(); tq_a.delete();
        @(negedge clk);
        en_a = 1'b1;
        for (int n = 0; n < 4000 && nq_a.size() < 204; n++) @(negedge clk);
        en_a = 1'b0;
        for (int n = 0; n < 500 && busy_a !== 1'b0; n++) @(negedge clk);
        repeat (40) @(negedge clk);
        check("a_f0_cmd", bytes_of(nq_a, 0, 1), 8'h80);
        check("a_f0_cmd_rs", rs_of(nq_a, 0, 1), 0);
        check("a_f0_line", bytes_of(nq_a, 2, 8), "HELLOHEL");
        check("a_f0_rs", rs_of(nq_a, 2, 8), 16'hFFFF);
        check("a_data_gap", tq_a[4] - tq_a[2], 16);
        check("a_f1_line", bytes_of(nq_a, 18 + 2, 8), "HELLOHEL");
        check("a_f2_line", bytes_of(nq_a, 36 + 2, 8), "ELLOHELL");
        check("a_f8_line", bytes_of(nq_a, 144 + 2, 8), "OHELLOHE");
        check("a_f10_line", bytes_of(nq_a, 180 + 2, 8), "HELLOHEL");
        check("a_f11_line", bytes_of(nq_a, 198 + 2, 8), "HELLOHEL");
        check("a_en_drop_nibbles", nq_a.size(), 216);
        check("a_en_drop_idle", {busy_a, e_a, rs_a, d7_a, d6_a, d5_a, d4_a}, 0);

        // reset while E is high inside a data byte
        en_a = 1'b1;
        for (int n = 0; n < 300 && !(e_a === 1'b1 && rs_a === 1'b1); n++) @(negedge clk);
        check("a_mid_data_e", {e_a, rs_a}, 2'b11);
        rst_a = 1'b1; en_a = 1'b0;
        @(posedge clk);
        #1 r = cyc;
        @(negedge clk);
        check("a_rst_mid_pins", {e_a, rs_a, d7_a, d6_a, d5_a, d4_a, busy_a, addr_a}, 10'h008);
        rst_a = 1'b0;
        nq_a.delete(); tq_a.delete();
        check_init_a("a_reinit", r);

        // two-line panel, static window: 20 nibbles per frame after 12 init nibbles
        check("b_init_nibbles", nq_b.size(), 12);
        check("b_func", bytes_of(nq_b, 4, 1), 8'h28);
        en_b = 1'b1;
        for (int n = 0; n < 2000 && nq_b.size() < 57; n++) @(negedge clk);
        en_b = 1'b0;
        for (int n = 0; n < 500 && busy_b !== 1'b0; n++) @(negedge clk);
        repeat (20) @(negedge clk);
        check("b_frames_nibbles", nq_b.size(), 72);
        check("b_idle_pins", {busy_b, e_b, rs_b, d7_b, d6_b, d5_b, d4_b}, 0);
        fb = 12;
        check("b_f0_cmd", bytes_of(nq_b, fb, 1), 8'h80);
        check("b_f0_l1", bytes_of(nq_b, fb + 2, 4), "ABCD");
        check("b_f0_c0", bytes_of(nq_b, fb + 10, 1), 8'hC0);
        check("b_f0_c0_rs", rs_of(nq_b, fb + 10, 1), 0);
        check("b_f0_l2", bytes_of(nq_b, fb + 12, 4), "EFGH");
        check("b_f0_l2_rs", rs_of(nq_b, fb + 12, 4), 16'h00FF);
        ap = '0;
        for (int j = 0; j < 4; j++) ap = {ap[23:0], 5'd0, aq_b[fb+12+2*j]};
        check("b_f0_l2_addr", ap, 32'h04050607);
        fb = 12 + 40;
        check("b_f2_l1", bytes_of(nq_b, fb + 2, 4), "ABCD");
        check("b_f2_l2", bytes_of(nq_b, fb + 12, 4), "EFGH");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
